// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle for one side of a pipeline stage: valid/ready plus the
// per-entry payload (control vector, destination index, two data words).
// The producer of an entry uses the master modport; the consumer uses slave.
interface pipe_stage_skid_if #(
  parameter int CTRL_W = 3,
  parameter int DEST_W = 5,
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DEST_W-1:0] dest;
  logic [DATA_W-1:0] data0;
  logic [DATA_W-1:0] data1;

  modport master (output valid, ctrl, dest, data0, data1, input ready);
  modport slave  (input valid, ctrl, dest, data0, data1, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a 2-entry skid buffer (main + skid),
// valid/ready handshake and synchronous flush. Full throughput, 1-cycle
// latency; in_ready is registered (it is simply !skid_valid).
// Optional: define PIPE_PERF_CNT_EN to add saturating stall/bubble counters.
module pipe_stage_skid #(
  parameter int CTRL_W = 3,
  parameter int DEST_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  pipe_stage_skid_if.slave    up_if,
  pipe_stage_skid_if.master   dn_if
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]         stall_cnt_o,
  output logic [31:0]         bubble_cnt_o
`endif
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;
  } entry_t;

  entry_t main_q, main_d, skid_q, skid_d, in_entry;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   push, pop;

  assign in_entry = '{ctrl: up_if.ctrl, dest: up_if.dest,
                      data0: up_if.data0, data1: up_if.data1};

  // A full skid is the only reason to refuse input, so ready is a flop output.
  assign up_if.ready = !skid_valid_q;
  assign push        = up_if.valid && !skid_valid_q;
  assign pop         = main_valid_q && dn_if.ready;

  // Next-state: skid always drains into main before newer input is admitted.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush_i) begin
      // Payload left stale on purpose; the masked ctrl makes it a bubble.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || pop) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = push;
        if (push) skid_d = in_entry;
      end else begin
        main_valid_d = push;
        if (push) main_d = in_entry;
      end
    end else if (push) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
  end

  // State registers; reset clears payload too so outputs read all-zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign dn_if.valid = main_valid_q;
  assign dn_if.ctrl  = main_q.ctrl & {CTRL_W{main_valid_q}};
  assign dn_if.dest  = main_q.dest;
  assign dn_if.data0 = main_q.data0;
  assign dn_if.data1 = main_q.data1;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, bubble_cnt_q;

  // Saturating counters of observed output stalls and empty cycles; flush
  // deliberately leaves them alone so a flush storm stays visible.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (main_valid_q && !dn_if.ready && stall_cnt_q != 32'hFFFF_FFFF)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (!main_valid_q && bubble_cnt_q != 32'hFFFF_FFFF)
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a cycle-by-cycle vector table for the
// basic/stall paths plus hand-written flush, reset-mid-stall and stream runs.
module tb_pipe_stage_skid;
  logic clk_i = 1'b0;
  logic rst_i;
  logic flush_i;
  int   n_chk  = 0;
  int   n_fail = 0;

  pipe_stage_skid_if #(.CTRL_W(3), .DEST_W(5), .DATA_W(32)) up_if ();
  pipe_stage_skid_if #(.CTRL_W(3), .DEST_W(5), .DATA_W(32)) dn_if ();

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_o, bubble_cnt_o;
`endif

  pipe_stage_skid #(.CTRL_W(3), .DEST_W(5), .DATA_W(32)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .up_if   (up_if),
    .dn_if   (dn_if)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt_o  (stall_cnt_o),
    .bubble_cnt_o (bubble_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        iv;
    logic [2:0]  ic;
    logic [4:0]  id;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        ordy;
    logic        ev;
    logic        eir;
    logic [2:0]  ec;
    logic [4:0]  ed;
    logic [31:0] ed0;
    logic [31:0] ed1;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [2:0] c, input logic [4:0] d,
                       input logic [31:0] d0, input logic [31:0] d1, input logic ordy);
    up_if.valid = iv;
    up_if.ctrl  = c;
    up_if.dest  = d;
    up_if.data0 = d0;
    up_if.data1 = d1;
    dn_if.ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic eir,
                         input logic [2:0] ec, input logic [4:0] ed,
                         input logic [31:0] ed0, input logic [31:0] ed1, input logic pay);
    chk({tag, ".out_valid"}, 32'(dn_if.valid), 32'(ev));
    chk({tag, ".in_ready"},  32'(up_if.ready), 32'(eir));
    chk({tag, ".out_ctrl"},  32'(dn_if.ctrl),  32'(ec));
    if (pay) begin
      chk({tag, ".out_dest"},  32'(dn_if.dest), 32'(ed));
      chk({tag, ".out_data0"}, dn_if.data0,     ed0);
      chk({tag, ".out_data1"}, dn_if.data1,     ed1);
    end
  endtask

  initial begin
    //          iv  ic    id  d0        d1       rdy  ev eir ec    ed  ed0       ed1
    tbl[0]  = '{1, 3'd5, 5'd7, 32'h1234, 32'hAA, 1,   1, 1, 3'd5, 5'd7, 32'h1234, 32'hAA};
    tbl[1]  = '{0, 3'd0, 5'd0, 32'h0,    32'h0,  1,   0, 1, 3'd0, 5'd0, 32'h0,    32'h0};
    tbl[2]  = '{1, 3'd1, 5'd1, 32'hA0,   32'hA1, 0,   1, 1, 3'd1, 5'd1, 32'hA0,   32'hA1};
    tbl[3]  = '{1, 3'd2, 5'd2, 32'hB0,   32'hB1, 0,   1, 0, 3'd1, 5'd1, 32'hA0,   32'hA1};
    tbl[4]  = '{1, 3'd3, 5'd3, 32'hC0,   32'hC1, 0,   1, 0, 3'd1, 5'd1, 32'hA0,   32'hA1};
    tbl[5]  = '{1, 3'd3, 5'd3, 32'hC0,   32'hC1, 1,   1, 1, 3'd2, 5'd2, 32'hB0,   32'hB1};
    tbl[6]  = '{1, 3'd3, 5'd3, 32'hC0,   32'hC1, 1,   1, 1, 3'd3, 5'd3, 32'hC0,   32'hC1};
    tbl[7]  = '{0, 3'd0, 5'd0, 32'h0,    32'h0,  1,   0, 1, 3'd0, 5'd0, 32'h0,    32'h0};
    tbl[8]  = '{1, 3'd4, 5'd4, 32'hE0,   32'hE1, 0,   1, 1, 3'd4, 5'd4, 32'hE0,   32'hE1};
    tbl[9]  = '{1, 3'd6, 5'd5, 32'hF0,   32'hF1, 0,   1, 0, 3'd4, 5'd4, 32'hE0,   32'hE1};
    tbl[10] = '{1, 3'd7, 5'd6, 32'hD0,   32'hD1, 1,   1, 1, 3'd6, 5'd5, 32'hF0,   32'hF1};
    tbl[11] = '{1, 3'd7, 5'd6, 32'hD0,   32'hD1, 1,   1, 1, 3'd7, 5'd6, 32'hD0,   32'hD1};
    tbl[12] = '{0, 3'd0, 5'd0, 32'h0,    32'h0,  1,   0, 1, 3'd0, 5'd0, 32'h0,    32'h0};

    // Reset state
    rst_i = 1'b1; flush_i = 1'b0;
    drive(0, 0, 0, 0, 0, 1);
    tick(); tick();
    chk_out("reset", 0, 1, 3'd0, 5'd0, 32'h0, 32'h0, 1);
    rst_i = 1'b0;

    // Table: single push, stall A/B/C, skid drain with D offered
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].iv, tbl[i].ic, tbl[i].id, tbl[i].d0, tbl[i].d1, tbl[i].ordy);
      tick();
      chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].eir, tbl[i].ec, tbl[i].ed,
              tbl[i].ed0, tbl[i].ed1, tbl[i].ev);
    end

    // Flush with main+skid full and new input offered
    drive(1, 3'd7, 5'd9, 32'h111, 32'h0, 0); tick();
    drive(1, 3'd7, 5'd10, 32'h222, 32'h0, 0); tick();
    chk("flush_pre.in_ready", 32'(up_if.ready), 32'd0);
    flush_i = 1'b1;
    drive(1, 3'd7, 5'd11, 32'h333, 32'h0, 0); tick();
    flush_i = 1'b0;
    chk_out("flush", 0, 1, 3'd0, 5'd0, 32'h0, 32'h0, 0);
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("flush_after%0d.out_valid", i), 32'(dn_if.valid), 32'd0);
    end

    // Reset asserted mid-stall: both entries lost, payload zeroed
    drive(1, 3'd5, 5'd12, 32'h444, 32'h4, 0); tick();
    drive(1, 3'd5, 5'd13, 32'h555, 32'h5, 0); tick();
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    chk_out("rst_stall", 0, 1, 3'd0, 5'd0, 32'h0, 32'h0, 1);
    drive(0, 0, 0, 0, 0, 1); tick();
    chk("rst_stall_after.out_valid", 32'(dn_if.valid), 32'd0);

    // Stream 8 entries back-to-back at full rate
    for (int i = 0; i < 8; i++) begin
      drive(1, 3'd1, 5'(i), 32'(i), 32'(i + 100), 1);
      tick();
      chk($sformatf("stream%0d.in_ready", i), 32'(up_if.ready), 32'd1);
      chk($sformatf("stream%0d.out_valid", i), 32'(dn_if.valid), 32'd1);
      chk($sformatf("stream%0d.out_data0", i), dn_if.data0, 32'(i));
    end
    drive(0, 0, 0, 0, 0, 1); tick();
    chk("stream_end.out_valid", 32'(dn_if.valid), 32'd0);

`ifdef PIPE_PERF_CNT_EN
    // 3 idle cycles, one push edge (still a bubble), 4 stall edges, then flush
    rst_i = 1'b1; drive(0, 0, 0, 0, 0, 1); tick(); rst_i = 1'b0;
    chk("perf_rst.stall", stall_cnt_o, 32'd0);
    chk("perf_rst.bubble", bubble_cnt_o, 32'd0);
    tick(); tick(); tick();
    chk("perf_idle.bubble", bubble_cnt_o, 32'd3);
    drive(1, 3'd1, 5'd1, 32'h9, 32'h0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick(); tick(); tick();
    chk("perf_stall.stall", stall_cnt_o, 32'd4);
    chk("perf_stall.bubble", bubble_cnt_o, 32'd4);
    flush_i = 1'b1; dn_if.ready = 1'b1; tick(); flush_i = 1'b0;
    chk("perf_flush.stall", stall_cnt_o, 32'd4);
    chk("perf_flush.bubble", bubble_cnt_o, 32'd4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
